// File: rtl/cgp_reg_array_pkg.sv
// Shared constants, gene layout and helpers for the CGP register-array evaluator.
// Everything that depends on the grid size is derived inside the modules.
package cgp_pkg;

  localparam int SRC_CONST0  = 0;
  localparam int SRC_IN_BASE = 1;

  localparam int GENE_LUT_LSB = 0;
  localparam int GENE_LUT_W   = 16;
  localparam int GENE_SEL_LSB = GENE_LUT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int src_node_base(input int n_in);
    return SRC_IN_BASE + n_in;
  endfunction

  function automatic logic lut4_eval(input logic [15:0] init, input logic [3:0] idx);
    return init[idx];
  endfunction

endpackage

// File: rtl/cgp_reg_array_lut_cell.sv
// One registered CGP node: four source muxes, a LUT4 lookup and a clearable register.
// Selectors beyond the source bus read as constant 0 via the zero-padded bus.
module cgp_lut_cell
  import cgp_pkg::*;
#(
  parameter int NSRC   = 20,
  parameter int SEL_W  = 5,
  parameter int GENE_W = 16 + 4 * SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [NSRC-1:0]   src,
  input  logic [GENE_W-1:0] gene,
  output logic              q
);

  logic [2**SEL_W-1:0] src_ext;
  logic [3:0]          idx;

  always_comb begin
    src_ext = '0;
    src_ext[NSRC-1:0] = src;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      idx[i] = src_ext[gene[GENE_SEL_LSB + i * SEL_W +: SEL_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (clr) begin
      q <= 1'b0;
    end else if (en) begin
      q <= lut4_eval(gene[GENE_LUT_LSB +: GENE_LUT_W], idx);
    end
  end

endmodule

// File: rtl/cgp_reg_array.sv
// Runtime-reconfigurable CGP evaluator: shadow/active genome store, evaluation FSM
// and the grid of registered LUT cells (nodes first, then output LUTs).
module cgp_reg_array
  import cgp_pkg::*;
#(
  parameter int N_IN  = 10,
  parameter int N_OUT = 10,
  parameter int COLS  = 3,
  parameter int ROWS  = 3,
  parameter int ITER  = 4,
  localparam int NODES  = COLS * ROWS,
  localparam int NSRC   = 1 + N_IN + NODES,
  localparam int SEL_W  = $clog2(NSRC),
  localparam int GENE_W = 16 + 4 * SEL_W,
  localparam int NGENES = NODES + N_OUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [GENE_W-1:0] cfg_data,
  input  logic              cfg_last,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_IN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_OUT-1:0]  out_data
);

  localparam int CNT_W  = $clog2(NGENES + 2);
  localparam int STEP_W = $clog2(ITER + 1);

  state_t              state;
  logic [STEP_W-1:0]   step;
  logic [N_IN-1:0]     in_reg;
  logic [CNT_W-1:0]    wcnt;
  logic [CNT_W-1:0]    cnt_inc;
  logic                pending;
  logic [GENE_W-1:0]   shadow [NGENES];
  logic [GENE_W-1:0]   active [NGENES];
  logic [NGENES-1:0]   cell_q;
  logic [NSRC-1:0]     src;
  logic                cfg_fire;
  logic                in_fire;
  logic                commit;

  assign cfg_ready = !pending;
  assign in_ready  = (state == ST_IDLE) && !pending;
  assign out_valid = (state == ST_DONE);
  assign out_data  = cell_q[NGENES-1:NODES];

  assign cfg_fire = cfg_valid && cfg_ready;
  assign in_fire  = in_valid && in_ready;
  assign commit   = (state == ST_IDLE) && pending;

  // Saturating count keeps overlong genomes distinguishable from exact ones.
  assign cnt_inc = (wcnt == CNT_W'(NGENES + 1)) ? wcnt : wcnt + 1'b1;

  // Bit 0 is the constant-0 source; inputs and node registers follow.
  assign src = {cell_q[NODES-1:0], in_reg, 1'b0};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      step    <= '0;
      in_reg  <= '0;
      wcnt    <= '0;
      pending <= 1'b0;
      cfg_err <= 1'b0;
      for (int g = 0; g < NGENES; g++) begin
        shadow[g] <= '0;
        active[g] <= '0;
      end
    end else begin
      if (cfg_fire) begin
        for (int g = 0; g < NGENES; g++) begin
          if (wcnt == CNT_W'(g)) shadow[g] <= cfg_data;
        end
        if (cfg_last) begin
          wcnt <= '0;
          if (cnt_inc == CNT_W'(NGENES)) pending <= 1'b1;
          else                           cfg_err <= 1'b1;
        end else begin
          wcnt <= cnt_inc;
        end
      end

      if (commit) begin
        for (int g = 0; g < NGENES; g++) active[g] <= shadow[g];
        pending <= 1'b0;
        cfg_err <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (in_fire) begin
            in_reg <= in_data;
            step   <= '0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          step <= step + 1'b1;
          if (step == STEP_W'(ITER - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NGENES; g++) begin : g_cell
    cgp_lut_cell #(
      .NSRC  (NSRC),
      .SEL_W (SEL_W),
      .GENE_W(GENE_W)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (in_fire),
      .en   (state == ST_RUN),
      .src  (src),
      .gene (active[g]),
      .q    (cell_q[g])
    );
  end

endmodule

// File: tb/tb_cgp_reg_array.sv
// Directed bench for cgp_reg_array: genome loads, evaluation results, commit timing,
// backpressure, reset and out-of-range selectors against hand-computed values.
module tb_cgp_reg_array;

  localparam int N_IN = 10, N_OUT = 10, ITER = 4;
  localparam int GENE_W = 36, NGENES = 19;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_valid, cfg_ready, cfg_last, cfg_err;
  logic [GENE_W-1:0] cfg_data;
  logic              in_valid, in_ready;
  logic [N_IN-1:0]   in_data;
  logic              out_valid, out_ready;
  logic [N_OUT-1:0]  out_data;

  int n_assert = 0;
  int n_fail   = 0;
  logic [GENE_W-1:0] gen [NGENES];

  always #5 clk = ~clk;

  cgp_reg_array #(
    .N_IN(N_IN), .N_OUT(N_OUT), .COLS(3), .ROWS(3), .ITER(ITER)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .cfg_last(cfg_last), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [GENE_W-1:0] mk(input int s3, input int s2, input int s1,
                                           input int s0, input logic [15:0] init);
    return {5'(s3), 5'(s2), 5'(s1), 5'(s0), init};
  endfunction

  task automatic set_and();
    for (int i = 0; i < NGENES; i++) gen[i] = '0;
    gen[0] = mk(0, 0, 2, 1, 16'h0008);
    gen[9] = mk(0, 0, 0, 11, 16'h0002);
  endtask

  task automatic set_fb();
    for (int i = 0; i < NGENES; i++) gen[i] = '0;
    gen[0] = mk(0, 0, 0, 11, 16'h0001);
    gen[9] = mk(0, 0, 0, 11, 16'h0002);
  endtask

  // Streams gen[0..n-1]; cfg_last is raised on the final word when requested.
  task automatic load(input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (!cfg_ready && t < 50) begin tick(); t++; end
      if (t >= 50) chk("cfg_ready_wait", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1;
      cfg_data  = gen[i];
      cfg_last  = with_last && (i == n - 1);
      tick();
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic wait_in_ready();
    int t = 0;
    while (!in_ready && t < 50) begin tick(); t++; end
    if (t >= 50) chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [N_IN-1:0] vec,
                         input logic [N_OUT-1:0] exp, input int hold);
    int lat = 0;
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = vec;
    tick();
    in_valid = 1'b0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    chk({tag, "_latency"}, 32'(lat), 32'(ITER));
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    for (int h = 0; h < hold; h++) begin
      tick();
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(out_data), 32'(exp));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Blank genome: every output LUT is constant 0.
    run_vec("blank", 10'b11, 10'h000, 0);

    // AND genome; commit occupies the edge after the last word.
    set_and();
    load(NGENES, 1'b1);
    chk("and_pending_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("and_pending_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("and_commit_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("and_commit_in_ready", 32'(in_ready), 32'd1);
    run_vec("and_11", 10'b11, 10'h001, 0);
    run_vec("and_01", 10'b01, 10'h000, 0);
    run_vec("and_10", 10'b10, 10'h000, 0);

    // Short feedback genome is rejected; AND stays active.
    set_fb();
    load(NGENES - 1, 1'b1);
    chk("short_err", 32'(cfg_err), 32'd1);
    chk("short_cfg_ready", 32'(cfg_ready), 32'd1);
    run_vec("short_keeps_and", 10'b11, 10'h001, 0);

    // Full feedback genome clears the error on commit.
    load(NGENES, 1'b1);
    tick();
    chk("fb_err_clear", 32'(cfg_err), 32'd0);
    run_vec("fb_00", 10'b00, 10'h001, 0);

    // Commit requested mid-RUN waits for IDLE and wins over a waiting input.
    set_and();
    load(NGENES - 1, 1'b0);
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 10'b00;
    tick();
    in_valid  = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = gen[NGENES-1];
    cfg_last  = 1'b1;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    chk("run_cfg_ready", 32'(cfg_ready), 32'd0);
    begin
      int t = 0;
      while (!out_valid && t < 20) begin tick(); t++; end
      chk("run_done_reached", 32'(out_valid), 32'd1);
    end
    chk("run_old_genome", 32'(out_data), 32'h001);
    chk("done_cfg_ready", 32'(cfg_ready), 32'd0);
    in_valid  = 1'b1;
    in_data   = 10'b11;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("commit_prio_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("post_commit_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("post_commit_in_ready", 32'(in_ready), 32'd1);
    run_vec("new_and_00", 10'b00, 10'h000, 0);

    // Backpressure: result and handshakes frozen while out_ready is low.
    run_vec("bp_and_11", 10'b11, 10'h001, 5);

    // Reset three steps into RUN, when out0 already holds 1.
    wait_in_ready();
    in_valid = 1'b1;
    in_data  = 10'b11;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    tick();
    run_vec("rst_cleared_genome", 10'b11, 10'h000, 0);

    // Out-of-range selector reads constant 0.
    set_and();
    gen[9] = mk(0, 0, 0, 31, 16'h0002);
    load(NGENES, 1'b1);
    run_vec("sel_oob", 10'b11, 10'h000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
